// File: rtl/dnr_pkg.sv
// Shared types and constants for the dynamic noise filter sample sequencer.
//   dnr_seq_state_t : sequencer FSM states
//   DNR_DATA_W      : default PCM sample width
//   DROP_CNT_W      : width of the saturating dropped-sample counter
package dnr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        UPDATE = 2'd3
    } dnr_seq_state_t;

    localparam int unsigned DNR_DATA_W = 16;
    localparam int unsigned DROP_CNT_W = 8;

endpackage

// File: rtl/dnr_sample_sequencer_if.sv
// Bus bundle between the sequencer and its surroundings (SPI rx, filter core, SPI tx).
//   rx_valid/rx_data                 : received SPI sample (1-cycle pulse)
//   core_in_valid/data/ready         : sample handshake towards the filter core
//   core_out_valid/data              : filtered result from the core (1-cycle pulse)
//   noise_update/noise_upd_done      : noise-floor update request / completion pulse
//   tx_data/tx_valid                 : last filtered sample for the SPI shifter
// Modports: master = sequencer side, slave = environment side.
interface dnr_sample_sequencer_if
    import dnr_pkg::*;
#(
    parameter int unsigned DATA_W = DNR_DATA_W
);
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              core_in_valid;
    logic [DATA_W-1:0] core_in_data;
    logic              core_in_ready;
    logic              core_out_valid;
    logic [DATA_W-1:0] core_out_data;
    logic              noise_update;
    logic              noise_upd_done;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    modport master (
        input  rx_valid, rx_data, core_in_ready, core_out_valid, core_out_data,
               noise_upd_done,
        output core_in_valid, core_in_data, noise_update, tx_data, tx_valid
    );

    modport slave (
        output rx_valid, rx_data, core_in_ready, core_out_valid, core_out_data,
               noise_upd_done,
        input  core_in_valid, core_in_data, noise_update, tx_data, tx_valid
    );

endinterface

// File: rtl/dnr_sample_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
//   clk, reset (sync, active-high) : clock / flush
//   push, push_data                : write request; taken when not full, or when full with a pop
//   pop                            : remove head (ignored when empty)
//   head                           : current oldest entry
//   full, empty, count             : occupancy status
module dnr_sample_fifo
    import dnr_pkg::*;
#(
    parameter int unsigned DATA_W = DNR_DATA_W,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dnr_sample_sequencer.sv
// Sequences the dynamic noise filter core: buffers SPI samples in a FIFO, issues them one at a
// time to the core, captures each filtered result for SPI transmit and requests a noise-floor
// update every FRAME_LEN samples.
//   clk, reset (sync, active-high)
//   enable       : 1 = issue samples; 0 = finish the current transaction, then stay IDLE
//   clear_err    : pulse, clears sticky errors and drop_cnt (a same-cycle error wins)
//   bus          : rx / core / noise-update / tx signals (master side)
//   busy         : FSM not IDLE or FIFO not empty
//   err_overflow : sticky, an rx sample was dropped
//   err_timeout  : sticky, the core did not answer within TIMEOUT cycles
//   drop_cnt     : dropped-sample count, saturating
module dnr_sample_sequencer
    import dnr_pkg::*;
#(
    parameter int unsigned DATA_W     = DNR_DATA_W,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear_err,
    dnr_sample_sequencer_if.master bus,
    output logic                  busy,
    output logic                  err_overflow,
    output logic                  err_timeout,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int unsigned CNT_W   = $clog2(FRAME_LEN + 1);
    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);
    localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH + 1);

    dnr_seq_state_t        state_q, state_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]      sample_cnt_q, sample_cnt_d;
    logic [DATA_W-1:0]     tx_data_q;
    logic                  tx_valid_q;
    logic                  err_overflow_q, err_timeout_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d, drop_base;

    logic                  fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0]     fifo_head;
    logic [FCNT_W-1:0]     fifo_count;
    logic                  result_take, timeout_hit, wait_exit, overflow;

    dnr_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.rx_valid),
        .push_data (bus.rx_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign overflow = bus.rx_valid && fifo_full && !fifo_pop;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        sample_cnt_d = sample_cnt_q;
        fifo_pop     = 1'b0;
        result_take  = 1'b0;
        timeout_hit  = 1'b0;
        wait_exit    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) state_d = ISSUE;
            end
            // Valid is held regardless of enable until the core takes the sample.
            ISSUE: begin
                if (bus.core_in_ready) begin
                    fifo_pop     = 1'b1;
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    timer_d      = '0;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_q + TIMER_W'(1);
                if (bus.core_out_valid) begin
                    result_take = 1'b1;
                    wait_exit   = 1'b1;
                end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th cycle spent waiting.
                    timeout_hit = 1'b1;
                    wait_exit   = 1'b1;
                end
                if (wait_exit) begin
                    if (sample_cnt_q == CNT_W'(FRAME_LEN)) begin
                        sample_cnt_d = '0;
                        state_d      = UPDATE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            UPDATE: begin
                if (bus.noise_upd_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear first, then count the current drop, so a same-cycle drop survives the clear.
    always_comb begin
        drop_base  = clear_err ? '0 : drop_cnt_q;
        drop_cnt_d = drop_base;
        if (overflow && (drop_base != '1)) drop_cnt_d = drop_base + DROP_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            sample_cnt_q   <= '0;
            tx_data_q      <= '0;
            tx_valid_q     <= 1'b0;
            err_overflow_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            drop_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            sample_cnt_q   <= sample_cnt_d;
            tx_valid_q     <= result_take;
            if (result_take) tx_data_q <= bus.core_out_data;
            err_overflow_q <= overflow || (err_overflow_q && !clear_err);
            err_timeout_q  <= timeout_hit || (err_timeout_q && !clear_err);
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    // core_in_data is forced to zero outside ISSUE so the unreset FIFO storage never shows.
    assign bus.core_in_valid = (state_q == ISSUE);
    assign bus.core_in_data  = (state_q == ISSUE) ? fifo_head : '0;
    assign bus.noise_update  = (state_q == UPDATE);
    assign bus.tx_data       = tx_data_q;
    assign bus.tx_valid      = tx_valid_q;
    assign busy              = (state_q != IDLE) || (fifo_count != '0);
    assign err_overflow      = err_overflow_q;
    assign err_timeout       = err_timeout_q;
    assign drop_cnt          = drop_cnt_q;

endmodule

// File: tb/tb_dnr_sample_sequencer.sv
// Directed self-checking bench for dnr_sample_sequencer.
module tb_dnr_sample_sequencer;
    import dnr_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       clear_err = 1'b0;
    logic       busy, err_overflow, err_timeout;
    logic [7:0] drop_cnt;

    int n_total = 0;
    int n_bad   = 0;

    logic [15:0] issued [$];
    int          upd_seen;

    dnr_sample_sequencer_if #(.DATA_W(16)) bus ();

    dnr_sample_sequencer #(
        .DATA_W     (16),
        .FIFO_DEPTH (8),
        .FRAME_LEN  (16),
        .TIMEOUT    (255)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .clear_err    (clear_err),
        .bus          (bus),
        .busy         (busy),
        .err_overflow (err_overflow),
        .err_timeout  (err_timeout),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs;
        bus.rx_valid       = 1'b0;
        bus.rx_data        = '0;
        bus.core_in_ready  = 1'b0;
        bus.core_out_valid = 1'b0;
        bus.core_out_data  = '0;
        bus.noise_upd_done = 1'b0;
        clear_err          = 1'b0;
    endtask

    task automatic do_reset;
        clr_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Always-ready core answering one cycle after acceptance with data ^ 0x5A5A.
    // Optionally pushes push_n samples (base, base+1, ...) every other cycle.
    task automatic run_core(input int push_n, input logic [15:0] base, input int want,
                            input int budget);
        int          pushed  = 0;
        int          results = 0;
        int          cyc     = 0;
        logic        pend    = 1'b0;
        logic [15:0] pend_d  = '0;
        upd_seen = 0;
        issued.delete();
        while (results < want && cyc < budget) begin
            bus.core_in_ready  = 1'b1;
            bus.core_out_valid = pend;
            bus.core_out_data  = pend_d ^ 16'h5A5A;
            if (pend) results++;
            pend = 1'b0;
            if (bus.core_in_valid) begin
                issued.push_back(bus.core_in_data);
                pend   = 1'b1;
                pend_d = bus.core_in_data;
            end
            if (bus.noise_update) upd_seen++;
            if (pushed < push_n && (cyc % 2) == 0) begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = base + 16'(pushed);
                pushed++;
            end else begin
                bus.rx_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        clr_inputs();
        chk("run_results", 32'(results), 32'(want));
    endtask

    initial begin
        int n, txc, iss, upd_low;
        clr_inputs();
        enable = 1'b1;

        // 1: single sample, latency and capture
        do_reset();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_civ", 32'(bus.core_in_valid), 0);
        chk("rst_txd", 32'(bus.tx_data), 0);
        chk("rst_txv", 32'(bus.tx_valid), 0);
        chk("rst_upd", 32'(bus.noise_update), 0);
        chk("rst_errs", 32'({err_overflow, err_timeout}), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 16'h1234;
        tick();
        bus.rx_valid = 1'b0;
        chk("t1_civ_n1", 32'(bus.core_in_valid), 0);
        tick();
        chk("t1_civ_n2", 32'(bus.core_in_valid), 1);
        chk("t1_cid_n2", 32'(bus.core_in_data), 32'h1234);
        bus.core_in_ready = 1'b1;
        tick();
        bus.core_in_ready = 1'b0;
        chk("t1_civ_wait", 32'(bus.core_in_valid), 0);
        tick();
        bus.core_out_valid = 1'b1;
        bus.core_out_data  = 16'h0ABC;
        chk("t1_txv_early", 32'(bus.tx_valid), 0);
        tick();
        bus.core_out_valid = 1'b0;
        chk("t1_txv", 32'(bus.tx_valid), 1);
        chk("t1_txd", 32'(bus.tx_data), 32'h0ABC);
        chk("t1_idle", 32'(busy), 0);
        txc = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.tx_valid) txc++;
        end
        chk("t1_txv_once", 32'(txc), 0);

        // 2: frame of 16 then noise update handshake
        do_reset();
        run_core(16, 16'h1000, 16, 200);
        chk("t2_upd_early", 32'(upd_seen), 0);
        chk("t2_upd_rise", 32'(bus.noise_update), 1);
        chk("t2_txd", 32'(bus.tx_data), 32'(16'h100F ^ 16'h5A5A));
        for (int i = 0; i < 16; i++) chk("t2_order", 32'(issued[i]), 32'(16'h1000 + 16'(i)));
        iss = 0;
        upd_low = 0;
        for (int i = 0; i < 20; i++) begin
            bus.rx_valid = (i == 0);
            bus.rx_data  = 16'h1010;
            if (bus.core_in_valid) iss++;
            if (!bus.noise_update) upd_low++;
            tick();
        end
        bus.rx_valid = 1'b0;
        chk("t2_hold_noissue", 32'(iss), 0);
        chk("t2_hold_level", 32'(upd_low), 0);
        bus.noise_upd_done = 1'b1;
        chk("t2_upd_done_cyc", 32'(bus.noise_update), 1);
        tick();
        bus.noise_upd_done = 1'b0;
        chk("t2_upd_fall", 32'(bus.noise_update), 0);
        tick();
        chk("t2_17_civ", 32'(bus.core_in_valid), 1);
        chk("t2_17_cid", 32'(bus.core_in_data), 32'h1010);
        run_core(15, 16'h1011, 16, 200);
        chk("t2_f2_upd_early", 32'(upd_seen), 0);
        chk("t2_f2_upd_rise", 32'(bus.noise_update), 1);

        // 3: overflow with stalled core
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 16'h3000 + 16'(i);
            tick();
        end
        bus.rx_valid = 1'b0;
        chk("t3_ovf", 32'(err_overflow), 1);
        chk("t3_drop", 32'(drop_cnt), 2);
        chk("t3_hold_cid", 32'(bus.core_in_data), 32'h3000);
        clear_err    = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 16'hBEEF;
        tick();
        bus.rx_valid = 1'b0;
        chk("t3_errwins_ovf", 32'(err_overflow), 1);
        chk("t3_errwins_drop", 32'(drop_cnt), 1);
        tick();
        clear_err = 1'b0;
        chk("t3_clr_ovf", 32'(err_overflow), 0);
        chk("t3_clr_drop", 32'(drop_cnt), 0);
        run_core(0, 16'h0, 8, 100);
        for (int i = 0; i < 8; i++) chk("t3_order", 32'(issued[i]), 32'(16'h3000 + 16'(i)));
        chk("t3_drained", 32'(busy), 0);

        // 4: full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 16'h4000 + 16'(i);
            tick();
        end
        chk("t4_full_ovf", 32'(err_overflow), 0);
        chk("t4_head", 32'(bus.core_in_data), 32'h4000);
        bus.core_in_ready = 1'b1;
        bus.rx_data       = 16'h4008;
        tick();
        bus.core_in_ready  = 1'b0;
        bus.rx_data        = 16'h4009;
        bus.core_out_valid = 1'b1;
        bus.core_out_data  = 16'h7777;
        chk("t4_pp_ovf", 32'(err_overflow), 0);
        chk("t4_pp_drop", 32'(drop_cnt), 0);
        tick();
        clr_inputs();
        chk("t4_still_full", 32'(drop_cnt), 1);
        chk("t4_txd", 32'(bus.tx_data), 32'h7777);
        run_core(0, 16'h0, 8, 100);
        for (int i = 0; i < 8; i++) chk("t4_order", 32'(issued[i]), 32'(16'h4001 + 16'(i)));

        // 5: core timeout
        do_reset();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 16'h5555;
        tick();
        bus.rx_valid = 1'b0;
        tick();
        bus.core_in_ready = 1'b1;
        tick();
        bus.core_in_ready = 1'b0;
        n = 0;
        txc = 0;
        while (!err_timeout && n < 400) begin
            if (bus.tx_valid) txc++;
            tick();
            n++;
        end
        chk("t5_wait_cycles", 32'(n), 255);
        chk("t5_no_txv", 32'(txc), 0);
        chk("t5_txd_kept", 32'(bus.tx_data), 0);
        chk("t5_idle", 32'(busy), 0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("t5_clr", 32'(err_timeout), 0);

        // 6: reset in WAIT with entries queued, late result ignored
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.rx_valid      = 1'b1;
            bus.rx_data       = 16'h6000 + 16'(i);
            bus.core_in_ready = (i == 2);
            tick();
        end
        bus.core_in_ready = 1'b0;
        bus.rx_valid      = 1'b1;
        bus.rx_data       = 16'h6FFF;
        chk("t6_in_wait", 32'(bus.core_in_valid), 0);
        chk("t6_busy_pre", 32'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.rx_valid = 1'b0;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_outs", 32'({bus.core_in_valid, bus.noise_update, bus.tx_valid,
                            err_overflow, err_timeout}), 0);
        chk("t6_cid", 32'(bus.core_in_data), 0);
        bus.core_out_valid = 1'b1;
        bus.core_out_data  = 16'hDEAD;
        tick();
        bus.core_out_valid = 1'b0;
        tick();
        chk("t6_late_txv", 32'(bus.tx_valid), 0);
        chk("t6_late_txd", 32'(bus.tx_data), 0);
        chk("t6_late_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
